// File: rtl/wb_master_arbiter_pkg.sv
// wb_master_arbiter_pkg: state and grant encodings shared by the two-master
// Wishbone arbiter, plus the round-robin pick used on every arbitration edge.
package wb_master_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_OWN0    = 2'd1,
    ARB_OWN1    = 2'd2,
    ARB_BACKOFF = 2'd3
  } arb_state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  // Round-robin pick among pending CYCs; on a tie the master that did not
  // own the bus last wins (last_owner: 0 = M0, 1 = M1).
  function automatic arb_state_e arb_pick(input logic cyc0, input logic cyc1,
                                          input logic last_owner);
    arb_state_e s;
    s = ARB_IDLE;
    if (cyc0 && cyc1) s = last_owner ? ARB_OWN0 : ARB_OWN1;
    else if (cyc0)    s = ARB_OWN0;
    else if (cyc1)    s = ARB_OWN1;
    return s;
  endfunction

  // One-hot owner view of the state; BACKOFF and IDLE have no owner.
  function automatic logic [1:0] gnt_of(input arb_state_e s);
    logic [1:0] g;
    case (s)
      ARB_OWN0: g = GNT_M0;
      ARB_OWN1: g = GNT_M1;
      default:  g = GNT_NONE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/wb_arb_timeout.sv
// wb_arb_timeout: counts owner strobe cycles without ACK and flags the cycle
// in which the stall reaches TIMEOUT_CYCLES. Cleared on ACK, on release
// (active low) and after firing.
module wb_arb_timeout #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_WIDTH  = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic stb,
  input  logic ack,
  output logic tc
);

  logic [TIMEOUT_WIDTH-1:0] cnt;
  logic                     stall;

  assign stall = active & stb & ~ack;
  // Fires during the TIMEOUT_CYCLES-th stalled cycle so the FSM leaves at that edge.
  assign tc    = stall && (cnt == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

  // Stall counter: restart on ACK, on loss of ownership, or once it has fired.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (!active || ack || tc) cnt <= '0;
    else if (stall)              cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/wb_master_arbiter.sv
// wb_master_arbiter: two-master / one-slave Wishbone classic arbiter.
// M0 = host bridge, M1 = USB engine. Registered round-robin grant held for the
// owner's whole CYC; owner signals are steered to the slave combinationally.
// Optional WB_ARB_TIMEOUT_EN adds a stalled-strobe watchdog with a one-cycle
// BACKOFF and an err pulse to the offending master.
module wb_master_arbiter
  import wb_master_arbiter_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 14,
  parameter int DATA_WIDTH     = 32,
  parameter int SEL_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_WIDTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     m0_cyc,
  input  logic                     m0_stb,
  input  logic                     m0_we,
  input  logic [ADDRESS_WIDTH-1:0] m0_adr,
  input  logic [SEL_WIDTH-1:0]     m0_sel,
  input  logic [DATA_WIDTH-1:0]    m0_dat_mosi,
  output logic                     m0_ack,
  output logic                     m0_err,
  output logic [DATA_WIDTH-1:0]    m0_dat_miso,
  input  logic                     m1_cyc,
  input  logic                     m1_stb,
  input  logic                     m1_we,
  input  logic [ADDRESS_WIDTH-1:0] m1_adr,
  input  logic [SEL_WIDTH-1:0]     m1_sel,
  input  logic [DATA_WIDTH-1:0]    m1_dat_mosi,
  output logic                     m1_ack,
  output logic                     m1_err,
  output logic [DATA_WIDTH-1:0]    m1_dat_miso,
  output logic                     s_cyc,
  output logic                     s_stb,
  output logic                     s_we,
  output logic [ADDRESS_WIDTH-1:0] s_adr,
  output logic [SEL_WIDTH-1:0]     s_sel,
  output logic [DATA_WIDTH-1:0]    s_dat_mosi,
  input  logic                     s_ack,
  input  logic [DATA_WIDTH-1:0]    s_dat_miso,
  output logic [1:0]               gnt
);

  arb_state_e state, state_nxt;
  logic       last_owner, last_owner_nxt;   // 0 = M0, 1 = M1
  logic       tc;

  // State and round-robin history; reset biases the first tie toward M0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      last_owner <= 1'b1;
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
    end
  end

  // Next state: grant from IDLE/BACKOFF, hand over on release with no bubble,
  // divert a timed-out owner into BACKOFF.
  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    case (state)
      ARB_IDLE:    state_nxt = arb_pick(m0_cyc, m1_cyc, last_owner);
      ARB_OWN0: begin
        if (!m0_cyc) begin
          last_owner_nxt = 1'b0;
          state_nxt      = m1_cyc ? ARB_OWN1 : ARB_IDLE;
        end else if (tc) begin
          last_owner_nxt = 1'b0;
          state_nxt      = ARB_BACKOFF;
        end
      end
      ARB_OWN1: begin
        if (!m1_cyc) begin
          last_owner_nxt = 1'b1;
          state_nxt      = m0_cyc ? ARB_OWN0 : ARB_IDLE;
        end else if (tc) begin
          last_owner_nxt = 1'b1;
          state_nxt      = ARB_BACKOFF;
        end
      end
      // last_owner already names the offender, so it loses any tie here.
      ARB_BACKOFF: state_nxt = arb_pick(m0_cyc, m1_cyc, last_owner);
      default:     state_nxt = ARB_IDLE;
    endcase
  end

  // Owner-to-slave steering and ACK routing; everything idles low without an owner.
  // ACK is also gated by the owner's CYC so a strobe abandoned mid-cycle never sees it.
  always_comb begin
    s_cyc      = 1'b0;
    s_stb      = 1'b0;
    s_we       = 1'b0;
    s_adr      = '0;
    s_sel      = '0;
    s_dat_mosi = '0;
    m0_ack     = 1'b0;
    m1_ack     = 1'b0;
    case (state)
      ARB_OWN0: begin
        s_cyc      = m0_cyc;
        s_stb      = m0_stb & m0_cyc;
        s_we       = m0_we;
        s_adr      = m0_adr;
        s_sel      = m0_sel;
        s_dat_mosi = m0_dat_mosi;
        m0_ack     = s_ack & m0_stb & m0_cyc;
      end
      ARB_OWN1: begin
        s_cyc      = m1_cyc;
        s_stb      = m1_stb & m1_cyc;
        s_we       = m1_we;
        s_adr      = m1_adr;
        s_sel      = m1_sel;
        s_dat_mosi = m1_dat_mosi;
        m1_ack     = s_ack & m1_stb & m1_cyc;
      end
      default: ;
    endcase
  end

  assign m0_dat_miso = s_dat_miso;
  assign m1_dat_miso = s_dat_miso;
  assign gnt         = gnt_of(state);

`ifdef WB_ARB_TIMEOUT_EN
  logic to_active;
  assign to_active = (state == ARB_OWN0 && m0_cyc) || (state == ARB_OWN1 && m1_cyc);

  wb_arb_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .active (to_active),
    .stb    (s_stb),
    .ack    (s_ack),
    .tc     (tc)
  );

  // err is the BACKOFF cycle itself, steered to whoever caused it.
  assign m0_err = (state == ARB_BACKOFF) && !last_owner;
  assign m1_err = (state == ARB_BACKOFF) &&  last_owner;
`else
  logic [TIMEOUT_WIDTH-1:0] unused_timeout;
  assign unused_timeout = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);
  assign tc     = 1'b0;
  assign m0_err = 1'b0;
  assign m1_err = 1'b0;
`endif

endmodule

// File: tb/tb_wb_master_arbiter.sv
// tb_wb_master_arbiter: directed arbitration scenarios followed by two random
// masters against a memoryless slave model, with a scoreboard monitor.
module tb_wb_master_arbiter;

  localparam int AW = 14;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_cyc, m0_stb, m0_we, m0_ack, m0_err;
  logic [AW-1:0] m0_adr;
  logic [SW-1:0] m0_sel;
  logic [DW-1:0] m0_dat_mosi, m0_dat_miso;
  logic          m1_cyc, m1_stb, m1_we, m1_ack, m1_err;
  logic [AW-1:0] m1_adr;
  logic [SW-1:0] m1_sel;
  logic [DW-1:0] m1_dat_mosi, m1_dat_miso;
  logic          s_cyc, s_stb, s_we, s_ack;
  logic [AW-1:0] s_adr;
  logic [SW-1:0] s_sel;
  logic [DW-1:0] s_dat_mosi, s_dat_miso;
  logic [1:0]    gnt;

  wb_master_arbiter #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW),
    .TIMEOUT_CYCLES(TO), .TIMEOUT_WIDTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr), .m0_sel(m0_sel),
    .m0_dat_mosi(m0_dat_mosi), .m0_ack(m0_ack), .m0_err(m0_err), .m0_dat_miso(m0_dat_miso),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr), .m1_sel(m1_sel),
    .m1_dat_mosi(m1_dat_mosi), .m1_ack(m1_ack), .m1_err(m1_err), .m1_dat_miso(m1_dat_miso),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_sel(s_sel),
    .s_dat_mosi(s_dat_mosi), .s_ack(s_ack), .s_dat_miso(s_dat_miso), .gnt(gnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] adr;
    logic [SW-1:0] sel;
    logic [DW-1:0] dat;
  } beat_t;

  typedef struct packed {
    logic          we;
    logic [DW-1:0] rdat;
  } mexp_t;

  beat_t exp_s[2][$];   // beats the slave should see, per issuing master
  mexp_t exp_m[2][$];   // responses each master should receive, in order
  int    n_chk = 0;
  int    n_fail = 0;
  bit    rand_phase = 0;
  bit    done[2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Slave model: read data is a fixed function of the word address.
  function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
    return 32'hC0DE_0000 ^ {18'h0, a} ^ {a, 18'h0};
  endfunction

  function automatic logic [1:0] oh(input int m);
    return (m != 0) ? 2'b10 : 2'b01;
  endfunction

  task automatic drv(input int m, input logic cyc, input logic stb, input logic we,
                     input logic [AW-1:0] adr, input logic [SW-1:0] sel, input logic [DW-1:0] dat);
    if (m == 0) begin
      m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_adr = adr; m0_sel = sel; m0_dat_mosi = dat;
    end else begin
      m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_adr = adr; m1_sel = sel; m1_dat_mosi = dat;
    end
  endtask

  task automatic expect_txn(input int m, input logic we, input logic [AW-1:0] adr,
                            input logic [SW-1:0] sel, input logic [DW-1:0] dat,
                            input logic [DW-1:0] rdat);
    beat_t b;
    mexp_t e;
    b.we = we; b.adr = adr; b.sel = sel; b.dat = dat;
    e.we = we; e.rdat = rdat;
    exp_s[m].push_back(b);
    exp_m[m].push_back(e);
  endtask

  task automatic mack(input int m, input logic [DW-1:0] d);
    mexp_t e;
    chk((m != 0) ? "m1_ack_owner" : "m0_ack_owner", 64'(gnt), 64'(oh(m)));
    if (exp_m[m].size() == 0) chk("m_ack_unexpected", 64'd1, 64'd0);
    else begin
      e = exp_m[m].pop_front();
      if (!e.we) chk((m != 0) ? "m1_rdata" : "m0_rdata", 64'(d), 64'(e.rdat));
    end
  endtask

  // Monitor: checks every slave-side beat and every master-side ACK against the queues.
  task automatic monitor();
    int    o;
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst_n && s_cyc && s_stb && s_ack) begin
        o = (gnt == 2'b10) ? 1 : 0;
        chk("slave_gnt_onehot", 64'($onehot(gnt)), 64'd1);
        if (exp_s[o].size() == 0) chk("slave_beat_unexpected", 64'd1, 64'd0);
        else begin
          e = exp_s[o].pop_front();
          chk("slave_beat", 64'({s_we, s_adr, s_sel, s_dat_mosi}), 64'(e));
        end
      end
      if (m0_ack) mack(0, m0_dat_miso);
      if (m1_ack) mack(1, m1_dat_miso);
      if (rand_phase && (m0_err || m1_err)) chk("err_in_random", 64'd1, 64'd0);
    end
  endtask

  task automatic master_run(input int m, input int n);
    logic          we;
    logic [AW-1:0] adr;
    logic [SW-1:0] sel;
    logic [DW-1:0] dat;
    bit            got;
    for (int t = 0; t < n; t++) begin
      repeat (1 + $urandom_range(0, 3)) @(posedge clk);
      #1;
      we = 1'($urandom_range(0, 1)); adr = AW'($urandom); sel = SW'($urandom); dat = $urandom;
      drv(m, 1'b1, 1'b1, we, adr, sel, dat);
      expect_txn(m, we, adr, sel, dat, rd_model(adr));
      got = 0;
      for (int c = 0; c < 200 && !got; c++) begin
        @(negedge clk);
        if ((m == 0 && m0_ack) || (m == 1 && m1_ack)) got = 1;
      end
      if (!got) chk("rand_ack_wait", 64'd0, 64'd1);
      @(posedge clk); #1;
      drv(m, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    end
    done[m] = 1;
  endtask

  task automatic slave_run();
    int dly = 0;
    for (int c = 0; c < 20000 && !(done[0] && done[1]); c++) begin
      @(posedge clk); #2;
      if (s_ack) s_ack = 1'b0;
      else if (s_cyc && s_stb) begin
        if (dly == 0) begin
          s_ack = 1'b1;
          s_dat_miso = rd_model(s_adr);
          dly = $urandom_range(0, 2);
        end else dly--;
      end
    end
    s_ack = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cur;
    rst_n = 1'b0; s_ack = 1'b0; s_dat_miso = '0;
    drv(0, 0, 0, 0, '0, '0, '0);
    drv(1, 0, 0, 0, '0, '0, '0);
    fork monitor(); join_none

    // Reset state
    #12;
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_s_bus", 64'({s_cyc, s_stb, s_we, s_adr, s_sel, s_dat_mosi}), 64'd0);
    chk("rst_acks_errs", 64'({m0_ack, m1_ack, m0_err, m1_err}), 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    // M0 single write
    @(posedge clk); #1;
    drv(0, 1, 1, 1, 14'h0010, 4'hF, 32'hDEADBEEF);
    expect_txn(0, 1'b1, 14'h0010, 4'hF, 32'hDEADBEEF, '0);
    @(negedge clk);
    chk("gnt_latency", 64'(gnt), 64'd0);
    chk("s_cyc_before_gnt", 64'(s_cyc), 64'd0);
    @(posedge clk); #2; s_ack = 1'b1;
    @(negedge clk);
    chk("m0_gnt", 64'(gnt), 64'b01);
    chk("m0_write_bus", 64'({s_cyc, s_stb, s_we, s_adr, s_sel, s_dat_mosi}),
        64'({1'b1, 1'b1, 1'b1, 14'h0010, 4'hF, 32'hDEADBEEF}));
    chk("m0_ack_fwd", 64'({m0_ack, m1_ack}), 64'b10);
    @(posedge clk); #1; drv(0, 0, 0, 0, '0, '0, '0); #1; s_ack = 1'b0;
    @(negedge clk); chk("release_s_cyc", 64'(s_cyc), 64'd0);
    @(posedge clk); @(negedge clk); chk("release_idle", 64'(gnt), 64'd0);

    // Simultaneous request after reset, then strict alternation
    do_reset();
    drv(0, 1, 0, 0, '0, '0, '0);
    drv(1, 1, 0, 0, '0, '0, '0);
    @(negedge clk); chk("tie_latency", 64'(gnt), 64'd0);
    @(posedge clk); @(negedge clk); chk("tie_first_m0", 64'(gnt), 64'b01);
    cur = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1; drv(cur, 0, 0, 0, '0, '0, '0);
      @(negedge clk); chk("rr_hold_until_edge", 64'(gnt), 64'(oh(cur)));
      @(posedge clk); #1; drv(cur, 1, 0, 0, '0, '0, '0);
      cur = 1 - cur;
      @(negedge clk); chk("rr_alternate", 64'(gnt), 64'(oh(cur)));
    end
    @(posedge clk); #1;
    drv(0, 0, 0, 0, '0, '0, '0);
    drv(1, 0, 0, 0, '0, '0, '0);
    @(posedge clk); #1;
    drv(0, 1, 0, 0, '0, '0, '0);
    drv(1, 1, 0, 0, '0, '0, '0);
    @(posedge clk); @(negedge clk); chk("tie_last_owner_loses", 64'(gnt), 64'(oh(1 - cur)));
    @(posedge clk); #1;
    drv(0, 0, 0, 0, '0, '0, '0);
    drv(1, 0, 0, 0, '0, '0, '0);
    @(posedge clk); @(posedge clk);

    // M1 read while M0 waits
    #1;
    drv(1, 1, 1, 0, 14'h0123, 4'hF, '0);
    expect_txn(1, 1'b0, 14'h0123, 4'hF, '0, 32'h12345678);
    @(posedge clk); #1;
    drv(0, 1, 1, 1, 14'h0200, 4'h3, 32'hA5A5A5A5);
    expect_txn(0, 1'b1, 14'h0200, 4'h3, 32'hA5A5A5A5, '0);
    #1; s_ack = 1'b1; s_dat_miso = 32'h12345678;
    @(negedge clk);
    chk("m1_read_gnt", 64'(gnt), 64'b10);
    chk("m1_read_ack", 64'({m1_ack, m0_ack}), 64'b10);
    chk("m1_read_data", 64'(m1_dat_miso), 64'h12345678);
    @(posedge clk); #1; drv(1, 0, 0, 0, '0, '0, '0); #1; s_ack = 1'b0;
    @(negedge clk);
    chk("m1_ack_one_cycle", 64'({m1_ack, m0_ack}), 64'd0);
    @(posedge clk); #2; s_ack = 1'b1; s_dat_miso = '0;
    @(negedge clk);
    chk("handover_no_bubble", 64'(gnt), 64'b01);
    chk("m0_ack_after_wait", 64'(m0_ack), 64'd1);
    @(posedge clk); #1; drv(0, 0, 0, 0, '0, '0, '0); #1; s_ack = 1'b0;
    @(posedge clk); @(posedge clk);

    // Owner abandons a strobe; a late ACK must go nowhere
    #1; drv(0, 1, 1, 0, 14'h0055, 4'hF, '0);
    @(posedge clk); @(negedge clk); chk("abort_pre_stb", 64'({s_cyc, s_stb}), 64'b11);
    @(posedge clk); #1; drv(0, 0, 0, 0, '0, '0, '0);
    @(negedge clk); chk("abort_same_cycle", 64'({s_cyc, s_stb}), 64'd0);
    @(posedge clk); #2; s_ack = 1'b1;
    @(negedge clk);
    chk("late_ack_dropped", 64'({m0_ack, m1_ack}), 64'd0);
    chk("late_ack_idle", 64'(gnt), 64'd0);
    @(posedge clk); #2; s_ack = 1'b0;

    // Hung slave: M0 strobes, M1 waits
    @(posedge clk); #1; drv(0, 1, 1, 1, 14'h03FF, 4'hF, 32'h1);
    @(posedge clk); #1; drv(1, 1, 0, 0, 14'h0007, 4'hF, '0);
`ifdef WB_ARB_TIMEOUT_EN
    for (int i = 1; i <= TO; i++) begin
      @(negedge clk);
      chk("to_no_early_err", 64'({m0_err, gnt}), 64'b001);
      @(posedge clk);
    end
    @(negedge clk);
    chk("to_m0_err", 64'({m0_err, m1_err}), 64'b10);
    chk("to_backoff_bus", 64'({gnt, s_cyc, s_stb}), 64'd0);
    @(posedge clk); #1; drv(0, 0, 0, 0, '0, '0, '0);
    @(negedge clk);
    chk("to_m1_after_backoff", 64'(gnt), 64'b10);
    chk("to_err_one_cycle", 64'(m0_err), 64'd0);
`else
    for (int i = 0; i < 2 * TO; i++) begin
      @(negedge clk);
      chk("no_timeout_err", 64'({m0_err, m1_err, gnt}), 64'b0001);
      @(posedge clk);
    end
    #1; drv(0, 0, 0, 0, '0, '0, '0);
    @(posedge clk); @(negedge clk); chk("no_timeout_release", 64'(gnt), 64'b10);
`endif
    @(posedge clk); #1; drv(1, 0, 0, 0, '0, '0, '0);
    @(posedge clk); @(posedge clk);

    // Asynchronous reset mid-transfer
    #1; drv(0, 1, 1, 0, 14'h0001, 4'hF, '0);
    @(posedge clk); @(negedge clk); chk("pre_async_rst_gnt", 64'(gnt), 64'b01);
    #2; rst_n = 1'b0;
    #1;
    chk("async_rst_s_cyc", 64'({s_cyc, s_stb}), 64'd0);
    chk("async_rst_gnt", 64'(gnt), 64'd0);
    @(posedge clk); #1; drv(0, 0, 0, 0, '0, '0, '0); rst_n = 1'b1;
    @(posedge clk);

    // Random traffic from both masters
    rand_phase = 1;
    fork
      master_run(0, 30);
      master_run(1, 30);
      slave_run();
    join
    rand_phase = 0;
    repeat (3) @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      chk("slave_queue_drained", 64'(exp_s[m].size()), 64'd0);
      chk("master_queue_drained", 64'(exp_m[m].size()), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
